// File: rtl/fan_timer_fsm.sv
// Fan power/speed and countdown-timer control driven by debounced button pulses.
// Optional build macro FAN_SPEED_MEMORY_EN keeps the speed level across power-off.
module fan_timer_fsm #(
    parameter int TICK_DIV     = 100_000_000,
    parameter int TIMER_STEP_S = 3,
    parameter int TIMER_MAX_S  = 9
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_power,
    input  logic       i_btn_speed,
    input  logic       i_btn_timer,
    output logic       o_FANOnOff,
    output logic       o_TIMEROnOff,
    output logic [3:0] o_1000_value,
    output logic [7:0] o_remain_s
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [7:0]       STEP_S   = 8'(TIMER_STEP_S);
    localparam logic [7:0]       MAX_S    = 8'(TIMER_MAX_S);

    typedef enum logic {S_OFF, S_ON}   fan_state_t;
    typedef enum logic {T_IDLE, T_RUN} tmr_state_t;

    fan_state_t       fan_state, fan_state_n;
    tmr_state_t       tmr_state, tmr_state_n;
    logic [1:0]       spd, spd_n;
    logic [7:0]       remain, remain_n;
    logic [PRE_W-1:0] pre, pre_n;
    logic             tick;

    // Extension is summed one bit wider so the ceiling clamp cannot be defeated by wrap.
    function automatic logic [7:0] sat_extend(input logic [7:0] r);
        logic [8:0] sum;
        sum = {1'b0, r} + {1'b0, STEP_S};
        if (sum > {1'b0, MAX_S})
            return MAX_S;
        return sum[7:0];
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fan_state <= S_OFF;
            tmr_state <= T_IDLE;
            spd       <= 2'd1;
            remain    <= 8'd0;
            pre       <= '0;
        end else begin
            fan_state <= fan_state_n;
            tmr_state <= tmr_state_n;
            spd       <= spd_n;
            remain    <= remain_n;
            pre       <= pre_n;
        end
    end

    assign tick = (tmr_state == T_RUN) && (pre == PRE_LAST);

    always_comb begin
        fan_state_n = fan_state;
        tmr_state_n = tmr_state;
        spd_n       = spd;
        remain_n    = remain;
        pre_n       = pre;

        if (tmr_state == T_RUN)
            pre_n = tick ? '0 : pre + PRE_ONE;

        if (fan_state == S_OFF) begin
            if (i_btn_power) begin
                fan_state_n = S_ON;
`ifdef FAN_SPEED_MEMORY_EN
                spd_n = spd;
`else
                spd_n = 2'd1;
`endif
            end
        end else if (i_btn_power) begin
            fan_state_n = S_OFF;
            tmr_state_n = T_IDLE;
            remain_n    = 8'd0;
            pre_n       = '0;
        end else begin
            if (i_btn_speed)
                spd_n = (spd == 2'd3) ? 2'd1 : spd + 2'd1;

            // A timer press wins over a coincident tick, so a press can never let it expire.
            if (i_btn_timer) begin
                if (tmr_state == T_IDLE) begin
                    tmr_state_n = T_RUN;
                    remain_n    = STEP_S;
                    pre_n       = '0;
                end else if (remain < MAX_S) begin
                    remain_n = sat_extend(remain);
                end else begin
                    tmr_state_n = T_IDLE;
                    remain_n    = 8'd0;
                    pre_n       = '0;
                end
            end else if (tick) begin
                if (remain == 8'd1) begin
                    fan_state_n = S_OFF;
                    tmr_state_n = T_IDLE;
                    remain_n    = 8'd0;
                    pre_n       = '0;
                end else begin
                    remain_n = remain - 8'd1;
                end
            end
        end
    end

    assign o_FANOnOff   = (fan_state == S_ON);
    assign o_TIMEROnOff = (tmr_state == T_RUN);
    assign o_1000_value = (fan_state == S_ON) ? {2'b00, spd} : 4'd0;
    assign o_remain_s   = remain;

endmodule

// File: tb/tb_fan_timer_fsm.sv
// Directed bench for fan_timer_fsm: vector table plus hand-written multi-cycle sequences.
module tb_fan_timer_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_power = 1'b0;
    logic       btn_speed = 1'b0;
    logic       btn_timer = 1'b0;
    logic       fan_on;
    logic       tmr_on;
    logic [3:0] level;
    logic [7:0] remain;

    int tests = 0;
    int fails = 0;

    fan_timer_fsm #(
        .TICK_DIV    (4),
        .TIMER_STEP_S(3),
        .TIMER_MAX_S (9)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_btn_power (btn_power),
        .i_btn_speed (btn_speed),
        .i_btn_timer (btn_timer),
        .o_FANOnOff  (fan_on),
        .o_TIMEROnOff(tmr_on),
        .o_1000_value(level),
        .o_remain_s  (remain)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pwr;
        logic       spd;
        logic       tmr;
        logic       fan;
        logic       ton;
        logic [3:0] val;
        logic [7:0] rem;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic e_fan, input logic e_ton,
                         input logic [3:0] e_val, input logic [7:0] e_rem);
        tests++;
        if (fan_on !== e_fan || tmr_on !== e_ton || level !== e_val || remain !== e_rem) begin
            fails++;
            $display("FAIL %s: got fan=%0b tmr=%0b val=%0d rem=%0d, want fan=%0b tmr=%0b val=%0d rem=%0d",
                     name, fan_on, tmr_on, level, remain, e_fan, e_ton, e_val, e_rem);
        end
    endtask

    // One clock with the given buttons held; outputs settle 1 time unit after the edge.
    task automatic press(input logic p, input logic s, input logic t);
        @(negedge clk);
        btn_power = p;
        btn_speed = s;
        btn_timer = t;
        @(posedge clk);
        #1;
        btn_power = 1'b0;
        btn_speed = 1'b0;
        btn_timer = 1'b0;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++)
            press(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] mem_exp;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 8'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 8'd3};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 8'd6};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 8'd9};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 8'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 8'd0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 1'b0, 1'b0, 4'd0, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            press(vecs[i].pwr, vecs[i].spd, vecs[i].tmr);
            check($sformatf("vec%0d", i), vecs[i].fan, vecs[i].ton, vecs[i].val, vecs[i].rem);
        end

        // Full countdown from a single press: 3 s at 4 cycles per second.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("arm", 1'b1, 1'b1, 4'd1, 8'd3);
        step(3);
        check("pre_tick", 1'b1, 1'b1, 4'd1, 8'd3);
        step(1);
        check("cd_2", 1'b1, 1'b1, 4'd1, 8'd2);
        step(4);
        check("cd_1", 1'b1, 1'b1, 4'd1, 8'd1);
        step(3);
        check("cd_pre_expire", 1'b1, 1'b1, 4'd1, 8'd1);
        step(1);
        check("cd_expire", 1'b0, 1'b0, 4'd0, 8'd0);

        // Extension from 8 saturates at 9, then the next press cancels.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        step(2);
        check("rem_8", 1'b1, 1'b1, 4'd1, 8'd8);
        press(1'b0, 1'b0, 1'b1);
        check("sat_9", 1'b1, 1'b1, 4'd1, 8'd9);
        press(1'b0, 1'b0, 1'b1);
        check("cancel", 1'b1, 1'b0, 4'd1, 8'd0);

        // Timer press on the expiring tick rescues the fan; power mid-run clears all.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        step(8);
        check("rem_1", 1'b1, 1'b1, 4'd1, 8'd1);
        step(3);
        press(1'b0, 1'b0, 1'b1);
        check("rescue", 1'b1, 1'b1, 4'd1, 8'd4);
        step(4);
        check("after_rescue", 1'b1, 1'b1, 4'd1, 8'd3);
        press(1'b1, 1'b0, 1'b0);
        check("power_mid_run", 1'b0, 1'b0, 4'd0, 8'd0);

        // Asynchronous reset between clock edges during a countdown.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        step(2);
        check("pre_async", 1'b1, 1'b1, 4'd2, 8'd3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 1'b0, 1'b0, 4'd0, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(5);
        check("post_reset_idle", 1'b0, 1'b0, 4'd0, 8'd0);

        // Speed level across a power cycle depends on the build option.
`ifdef FAN_SPEED_MEMORY_EN
        mem_exp = 4'd3;
`else
        mem_exp = 4'd1;
`endif
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("speed_3", 1'b1, 1'b0, 4'd3, 8'd0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("speed_memory", 1'b1, 1'b0, mem_exp, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
